// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchroniser, tick debounce, edge pulses
// and long-press / auto-repeat detection for buttons and switches.
module button_conditioner #(
  parameter int CHANNELS       = 5,
  parameter int TICK_DIV       = 104000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int HOLD_TICKS     = 500,
  parameter int REPEAT_TICKS   = 100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] held,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] rpt,
  output logic                tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW =
    (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam int RL = (REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0;
  localparam bit REP_ON = (REPEAT_TICKS != 0);

  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RL);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic [PW-1:0]       pre_cnt;
  logic [CHANNELS-1:0] meta;
  logic [CHANNELS-1:0] sync;

  // tick is registered so it is low in reset even when TICK_DIV == 1
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
      meta    <= '0;
      sync    <= '0;
    end else begin
      tick    <= (pre_cnt == P_LAST);
      pre_cnt <= (pre_cnt == P_LAST) ? '0 : pre_cnt + 1'b1;
      meta    <= noisy;
      sync    <= meta;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          cln_q, cln_d;
    logic [DW-1:0] db_q, db_d;
    logic [HW-1:0] hc_q, hc_d;
    logic [RW-1:0] rc_q, rc_d;
    state_t        st_q, st_d;
    logic          lp_d, rp_d;
    logic          rise_q, fall_q, lp_q, rp_q;

    always_comb begin
      cln_d = cln_q;
      db_d  = db_q;
      if (sync[i] == cln_q) begin
        db_d = '0;
      end else if (tick) begin
        if (db_q == D_LAST) begin
          cln_d = ~cln_q;
          db_d  = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
    end

    // a falling clean overrides any hold/repeat expiry on the same tick
    always_comb begin
      st_d = st_q;
      hc_d = hc_q;
      rc_d = rc_q;
      lp_d = 1'b0;
      rp_d = 1'b0;
      if (!cln_d) begin
        st_d = IDLE;
        hc_d = '0;
        rc_d = '0;
      end else begin
        unique case (st_q)
          IDLE: begin
            st_d = PRESSED;
            hc_d = '0;
            rc_d = '0;
          end
          PRESSED: begin
            if (tick) begin
              if (hc_q == H_LAST) begin
                st_d = HELD;
                lp_d = 1'b1;
                hc_d = '0;
                rc_d = '0;
              end else begin
                hc_d = hc_q + 1'b1;
              end
            end
          end
          HELD: begin
            if (tick && REP_ON) begin
              if (rc_q == R_LAST) begin
                rp_d = 1'b1;
                rc_d = '0;
              end else begin
                rc_d = rc_q + 1'b1;
              end
            end
          end
          default: st_d = IDLE;
        endcase
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cln_q  <= 1'b0;
        db_q   <= '0;
        hc_q   <= '0;
        rc_q   <= '0;
        st_q   <= IDLE;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        lp_q   <= 1'b0;
        rp_q   <= 1'b0;
      end else begin
        cln_q  <= cln_d;
        db_q   <= db_d;
        hc_q   <= hc_d;
        rc_q   <= rc_d;
        st_q   <= st_d;
        rise_q <= cln_d & ~cln_q;
        fall_q <= ~cln_d & cln_q;
        lp_q   <= lp_d;
        rp_q   <= rp_d;
      end
    end

    assign clean[i]      = cln_q;
    assign rise[i]       = rise_q;
    assign fall[i]       = fall_q;
    assign held[i]       = (st_q == HELD);
    assign long_press[i] = lp_q;
    assign rpt[i]        = rp_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: constant vector table plus a randomized run
// checked cycle by cycle against a tick-counting reference model.
module tb_button_conditioner;

  localparam int CH   = 2;
  localparam int TD   = 4;
  localparam int DEB  = 3;
  localparam int HOLD = 5;
  localparam int REP  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [CH-1:0] noisy = '0;
  logic [CH-1:0] clean, rise, fall, held, long_press, rpt;
  logic          tick;

  button_conditioner #(
    .CHANNELS(CH),
    .TICK_DIV(TD),
    .DEBOUNCE_TICKS(DEB),
    .HOLD_TICKS(HOLD),
    .REPEAT_TICKS(REP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .noisy(noisy),
    .clean(clean),
    .rise(rise),
    .fall(fall),
    .held(held),
    .long_press(long_press),
    .rpt(rpt),
    .tick(tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [1:0] drv;
    logic [1:0] cln;
    logic [1:0] ris;
    logic [1:0] fal;
    logic [1:0] hld;
    logic [1:0] lp;
    logic [1:0] rp;
    logic       tk;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state
  int            cyc = -1;
  int            run[CH];
  int            press[CH];
  logic [CH-1:0] mc, h_last, h_prev;
  logic [CH-1:0] e_cln, e_ris, e_fal, e_hld, e_lp, e_rp;
  logic          e_tk;

  function automatic void add(
    input int c, input logic [1:0] d,
    input logic [1:0] cl, input logic [1:0] ri,
    input logic [1:0] fa, input logic [1:0] hl,
    input logic [1:0] lp, input logic [1:0] rp,
    input logic tk);
    vec_t v;
    v.cyc = c; v.drv = d; v.cln = cl; v.ris = ri;
    v.fal = fa; v.hld = hl; v.lp = lp; v.rp = rp;
    v.tk = tk;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name,
                       input logic [6*CH:0] exp);
    logic [6*CH:0] act;
    act = {clean, rise, fall, held, long_press, rpt, tick};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    cyc = -1;
    mc = '0; h_last = '0; h_prev = '0;
    e_cln = '0; e_ris = '0; e_fal = '0;
    e_hld = '0; e_lp = '0; e_rp = '0; e_tk = 1'b0;
    for (int i = 0; i < CH; i++) begin
      run[i] = 0;
      press[i] = 0;
    end
  endtask

  // press[i] counts ticks spent with clean high after the rise
  task automatic model_step();
    logic          tk, nc;
    logic [CH-1:0] sy;
    tk = (cyc >= 0) && (cyc % TD == TD - 1);
    sy = h_prev;
    h_prev = h_last;
    h_last = noisy;
    for (int i = 0; i < CH; i++) begin
      nc = mc[i];
      if (sy[i] == mc[i]) run[i] = 0;
      else if (tk) begin
        run[i]++;
        if (run[i] == DEB) begin
          nc = ~mc[i];
          run[i] = 0;
        end
      end
      e_ris[i] = nc & ~mc[i];
      e_fal[i] = ~nc & mc[i];
      e_lp[i] = 1'b0;
      e_rp[i] = 1'b0;
      if (!nc) press[i] = 0;
      else if (mc[i] && tk) begin
        press[i]++;
        if (press[i] == HOLD) e_lp[i] = 1'b1;
        else if (REP != 0 && press[i] > HOLD &&
                 (press[i] - HOLD) % REP == 0)
          e_rp[i] = 1'b1;
      end
      e_hld[i] = nc && (press[i] >= HOLD);
      mc[i] = nc;
    end
    e_cln = mc;
    cyc++;
    e_tk = (cyc % TD == TD - 1);
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("model", {e_cln, e_ris, e_fal, e_hld, e_lp, e_rp, e_tk});
  endtask

  // reset lands mid-cycle so the zero check needs an async clear
  task automatic do_reset(input logic [CH-1:0] n);
    @(negedge clock);
    #2;
    reset = 1'b1;
    noisy = n;
    model_clear();
    #1;
    check("async_rst", '0);
    repeat (10) begin
      @(negedge clock);
      check("in_rst",
            {e_cln, e_ris, e_fal, e_hld, e_lp, e_rp, e_tk});
    end
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [CH-1:0] lvl, nz;
    // press, long press, repeats, release with fall beating rpt
    add(-1, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    add( 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    add( 3, 2'b01, 0, 0, 0, 0, 0, 0, 1);
    add(11, 2'b01, 0, 0, 0, 0, 0, 0, 1);
    add(12, 2'b01, 1, 1, 0, 0, 0, 0, 0);
    add(13, 2'b01, 1, 0, 0, 0, 0, 0, 0);
    add(31, 2'b01, 1, 0, 0, 0, 0, 0, 1);
    add(32, 2'b01, 1, 0, 0, 1, 1, 0, 0);
    add(33, 2'b01, 1, 0, 0, 1, 0, 0, 0);
    add(39, 2'b01, 1, 0, 0, 1, 0, 0, 1);
    add(40, 2'b01, 1, 0, 0, 1, 0, 1, 0);
    add(41, 2'b01, 1, 0, 0, 1, 0, 0, 0);
    add(48, 2'b01, 1, 0, 0, 1, 0, 1, 0);
    add(50, 2'b00, 1, 0, 0, 1, 0, 0, 0);
    add(56, 2'b00, 1, 0, 0, 1, 0, 1, 0);
    add(63, 2'b00, 1, 0, 0, 1, 0, 0, 1);
    add(64, 2'b00, 0, 0, 1, 0, 0, 0, 0);
    add(65, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(72, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    // bounce: low sample across tick 11 restarts the count
    add(-1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add( 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    add( 8, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(10, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    add(11, 2'b01, 0, 0, 0, 0, 0, 0, 1);
    add(23, 2'b01, 0, 0, 0, 0, 0, 0, 1);
    add(24, 2'b01, 1, 1, 0, 0, 0, 0, 0);
    add(25, 2'b01, 1, 0, 0, 0, 0, 0, 0);
    // both pressed; ch1 falls on its hold-expiry tick
    add(-1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add( 0, 2'b11, 0, 0, 0, 0, 0, 0, 0);
    add( 3, 2'b11, 0, 0, 0, 0, 0, 0, 1);
    add(12, 2'b11, 3, 3, 0, 0, 0, 0, 0);
    add(13, 2'b11, 3, 0, 0, 0, 0, 0, 0);
    add(18, 2'b01, 3, 0, 0, 0, 0, 0, 0);
    add(31, 2'b01, 3, 0, 0, 0, 0, 0, 1);
    add(32, 2'b01, 1, 0, 2, 1, 1, 0, 0);
    add(33, 2'b01, 1, 0, 0, 1, 0, 0, 0);
    add(36, 2'b01, 1, 0, 0, 1, 0, 0, 0);
    // reset while held, input still high: full debounce again
    add(-1, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    add( 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
    add(11, 2'b01, 0, 0, 0, 0, 0, 0, 1);
    add(12, 2'b01, 1, 1, 0, 0, 0, 0, 0);
    add(13, 2'b01, 1, 0, 0, 0, 0, 0, 0);

    model_clear();
    #12;
    foreach (tbl[k]) begin
      if (tbl[k].cyc < 0) begin
        do_reset(tbl[k].drv);
      end else begin
        while (cyc < tbl[k].cyc) step();
        check($sformatf("tbl%0d", k),
              {tbl[k].cln, tbl[k].ris, tbl[k].fal, tbl[k].hld,
               tbl[k].lp, tbl[k].rp, tbl[k].tk});
        noisy = tbl[k].drv;
      end
    end

    do_reset('0);
    lvl = '0;
    for (int n = 0; n < 4000; n++) begin
      step();
      if (n == 2000) do_reset(CH'($urandom));
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 79) == 0) lvl[i] = ~lvl[i];
        nz[i] = lvl[i] ^ ($urandom_range(0, 9) == 0);
      end
      noisy = nz;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Parametrised successor to the single-channel debouncer. Conditions CHANNELS noisy push-button or switch inputs for the Nexys4 top level:
- 2-flop synchroniser per channel
- tick-based debounce
- registered rise/fall edge pulses
- per-channel long-press detection with optional auto-repeat

It sits between the raw BTNx/SW pins and game/UI logic in the 104 MHz domain. It replaces the individual per-button debounce instances.

Parameters:
CHANNELS, 5, number of independent input channels (>=1)
TICK_DIV, 104000, clock cycles per sample tick (1 ms at 104 MHz); >=1, 1 = tick every cycle
DEBOUNCE_TICKS, 10, consecutive mismatching ticks needed to change clean (>=1)
HOLD_TICKS, 500, ticks a debounced press must last before long_press/held (>=1)
REPEAT_TICKS, 100, tick interval between rpt pulses while held; 0 disables repeat

Ports:
clock  in  1  system clock (clk_104mhz)
reset  in  1  asynchronous, active-high reset
noisy  in  CHANNELS  raw asynchronous inputs
clean  out  CHANNELS  debounced level
rise  out  CHANNELS  1-cycle pulse on clean 0->1
fall  out  CHANNELS  1-cycle pulse on clean 1->0
held  out  CHANNELS  level, high while channel is in HELD state
long_press  out  CHANNELS  1-cycle pulse on entry to HELD
rpt  out  CHANNELS  1-cycle auto-repeat pulse while HELD
tick  out  1  shared sample-tick pulse (debug / external use)

Behaviour:
Reset:
- Asynchronous; all registers clear immediately on reset assertion.
- All outputs are 0: synchronisers, clean, all pulses, held, tick.
- Prescaler, debounce, hold and repeat counters are 0; every FSM is IDLE.
- Asserting reset mid-press or mid-debounce discards all state. There is no pulse on reset release.

Prescaler:
- Counter runs 0..TICK_DIV-1 and wraps.
- tick=1 for exactly one cycle when the counter equals TICK_DIV-1.
- After reset release, the first tick is at cycle TICK_DIV-1 (cycles counted from 0 at the first edge after release).

Synchroniser:
- sync[i] = noisy[i] delayed by 2 flops. All further logic uses sync only.

Debounce (per channel):
- If sync==clean: db_cnt<=0 on any cycle, including tick cycles.
- If sync!=clean on a tick: db_cnt increments.
- If tick && sync!=clean && db_cnt==DEBOUNCE_TICKS-1: clean toggles and db_cnt<=0.
- Net effect: DEBOUNCE_TICKS consecutive mismatching ticks are required to toggle clean. Any matching sample between ticks resets the count.
- Glitches shorter than one tick period may go unseen. This is accepted.

Edges:
- rise/fall are registered and asserted in the same cycle clean first shows its new value. Width is exactly 1 cycle.

Hold FSM (per channel), states IDLE, PRESSED, HELD:
- IDLE -> PRESSED on the cycle clean becomes 1. hold_cnt<=0.
- PRESSED: on each tick, hold_cnt increments. On tick && hold_cnt==HOLD_TICKS-1: go to HELD, long_press=1 for 1 cycle, held=1, rep_cnt<=0.
- HELD: if REPEAT_TICKS!=0, rep_cnt increments on each tick. On tick && rep_cnt==REPEAT_TICKS-1: rpt=1 for 1 cycle and rep_cnt<=0.
- Any state -> IDLE on the cycle clean becomes 0 (the fall cycle). held drops in that same cycle and all counters clear.
- Priority: if clean falls in the same cycle hold or repeat would expire, fall wins. No long_press or rpt is emitted.
- long_press is never coincident with rpt: the first rpt comes REPEAT_TICKS ticks after long_press.

Independence and widths:
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Counter widths are $clog2 of the respective parameter, minimum 1 bit. No counter overflow is possible.

Test Plan:
(All with TICK_DIV=4, DEBOUNCE_TICKS=3, HOLD_TICKS=5, REPEAT_TICKS=2, CHANNELS=2; ticks on cycles 3, 7, 11, …)
1. Reset values: hold reset 10 cycles with noisy=2'b11 -> all outputs 0. Release -> first tick at cycle 3.
2. Clean press: noisy[0]=1 from cycle 0 -> sync=1 by cycle 2. Mismatch ticks 3, 7, 11 -> clean[0]=1 and rise[0]=1 at cycle 12 only. Channel 1 stays idle.
3. Bounce: noisy[0] high for ticks 3 and 7, low across tick 11, then steady high -> clean stays 0 until 3 fresh consecutive ticks. No spurious rise.
4. Long press/repeat: hold noisy[0] high:
   - long_press and held rise 5 ticks after the rise cycle.
   - rpt pulses every 2 ticks thereafter.
   - On release: fall, with held dropping in the fall cycle and no further rpt.
5. Simultaneous/priority:
   - Both channels pressed on the same cycle -> rise=2'b11 on the same cycle.
   - Release timed so clean falls on the long_press-expiry tick -> fall=1, long_press=0, held never 1.
6. Mid-operation reset: assert reset during HELD -> clean, held and pulses go 0 asynchronously. After release with noisy still high, the full debounce is repeated before rise.
